// File: rtl/rbm_vote_argmax_pkg.sv
// Shared types and default sizes for the RBM vote/argmax stage.
package rbm_vote_argmax_pkg;

    localparam int unsigned RBM_VA_OUT_DIM          = 2;
    localparam int unsigned RBM_VA_OUTPUT_BITLENGTH = 12;
    localparam int unsigned RBM_VA_ACC_BITLENGTH    = 20;
    localparam int unsigned RBM_VA_IDX_BITLENGTH    = 1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } rbm_va_state_t;

endpackage

// File: rtl/rbm_vote_argmax_if.sv
// Sample input and label output bundle between Main, the vote stage and the result sink.
interface rbm_vote_argmax_if
    import rbm_vote_argmax_pkg::*;
#(
    parameter int unsigned out_dim          = RBM_VA_OUT_DIM,
    parameter int unsigned output_bitlength = RBM_VA_OUTPUT_BITLENGTH,
    parameter int unsigned acc_bitlength    = RBM_VA_ACC_BITLENGTH,
    parameter int unsigned idx_bitlength    = RBM_VA_IDX_BITLENGTH
);
    logic [out_dim*output_bitlength-1:0] sample;
    logic                                sample_valid;
    logic                                finish;
    logic [idx_bitlength-1:0]            label;
    logic [acc_bitlength-1:0]            best_score;
    logic                                label_valid;
    logic                                label_ready;
    logic                                busy;
    logic                                overrun;

    modport master (
        output sample, sample_valid, finish, label_ready,
        input  label, best_score, label_valid, busy, overrun
    );

    modport slave (
        input  sample, sample_valid, finish, label_ready,
        output label, best_score, label_valid, busy, overrun
    );
endinterface

// File: rtl/rbm_sat_accumulator.sv
// Per-class saturating accumulator: adds an unsigned sample, clamps at all-ones.
module rbm_sat_accumulator #(
    parameter int unsigned acc_bitlength    = 20,
    parameter int unsigned output_bitlength = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic [output_bitlength-1:0] din,
    output logic [acc_bitlength-1:0]    q
);
    logic [acc_bitlength:0] sum;

    // One extra bit holds the carry that signals overflow.
    always_comb begin
        sum = {1'b0, q} + (acc_bitlength+1)'(din);
    end

    // Clear wins over accumulate; overflow clamps instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= sum[acc_bitlength] ? '1 : sum[acc_bitlength-1:0];
        end
    end
endmodule

// File: rtl/rbm_vote_argmax.sv
// Accumulates per-class votes, then runs a sequential argmax and hands the winner to the sink.
module rbm_vote_argmax
    import rbm_vote_argmax_pkg::*;
#(
    parameter int unsigned out_dim          = RBM_VA_OUT_DIM,
    parameter int unsigned output_bitlength = RBM_VA_OUTPUT_BITLENGTH,
    parameter int unsigned acc_bitlength    = RBM_VA_ACC_BITLENGTH,
    parameter int unsigned idx_bitlength    = RBM_VA_IDX_BITLENGTH
) (
    input  logic               clock,
    input  logic               reset,
    rbm_vote_argmax_if.slave   bus
);
    rbm_va_state_t            state;
    logic [acc_bitlength-1:0] acc [out_dim];
    logic [idx_bitlength-1:0] scan_idx;
    logic [idx_bitlength-1:0] best_idx;
    logic [acc_bitlength-1:0] best;
    logic [idx_bitlength-1:0] label_q;
    logic [acc_bitlength-1:0] best_score_q;
    logic                     label_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    logic                     acc_en;
    logic                     acc_clr;
    logic [acc_bitlength-1:0] cur;
    logic                     take;
    logic [acc_bitlength-1:0] next_best;
    logic [idx_bitlength-1:0] next_idx;
    logic                     last;

    assign acc_en  = bus.sample_valid && (state == ACCUM);
    assign acc_clr = (state == HOLD) && bus.label_ready;

    for (genvar i = 0; i < out_dim; i++) begin : g_acc
        rbm_sat_accumulator #(
            .acc_bitlength    (acc_bitlength),
            .output_bitlength (output_bitlength)
        ) u_acc (
            .clock (clock),
            .reset (reset),
            .clr   (acc_clr),
            .en    (acc_en),
            .din   (bus.sample[i*output_bitlength +: output_bitlength]),
            .q     (acc[i])
        );
    end

    // Compare step for the class under the scan pointer; strict > keeps the lowest index on ties.
    always_comb begin
        cur       = acc[scan_idx];
        take      = (scan_idx == '0) || (cur > best);
        next_best = take ? cur : best;
        next_idx  = take ? scan_idx : best_idx;
        last      = (scan_idx == idx_bitlength'(out_dim - 1));
    end

    // Control FSM with registered handshake outputs; the final compare result is
    // registered straight into label/best_score so HOLD is entered after out_dim scan cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ACCUM;
            scan_idx      <= '0;
            best_idx      <= '0;
            best          <= '0;
            label_q       <= '0;
            best_score_q  <= '0;
            label_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (bus.sample_valid && (state != ACCUM)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                ACCUM: begin
                    if (bus.finish) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    best     <= next_best;
                    best_idx <= next_idx;
                    if (last) begin
                        label_q       <= next_idx;
                        best_score_q  <= next_best;
                        label_valid_q <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.label_ready) begin
                        label_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state         <= ACCUM;
                    end
                end
                default: begin
                    state  <= ACCUM;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.label       = label_q;
    assign bus.best_score  = best_score_q;
    assign bus.label_valid = label_valid_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_rbm_vote_argmax.sv
// Directed bench for rbm_vote_argmax: default sizing plus a 12-bit accumulator instance.
module tb_rbm_vote_argmax;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rbm_vote_argmax_if #(.out_dim(2), .output_bitlength(12), .acc_bitlength(20), .idx_bitlength(1)) bus_a ();
    rbm_vote_argmax_if #(.out_dim(2), .output_bitlength(12), .acc_bitlength(12), .idx_bitlength(1)) bus_b ();

    rbm_vote_argmax #(.out_dim(2), .output_bitlength(12), .acc_bitlength(20), .idx_bitlength(1)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    rbm_vote_argmax #(.out_dim(2), .output_bitlength(12), .acc_bitlength(12), .idx_bitlength(1)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put_a(input int s0, input int s1);
        bus_a.sample       = {12'(s1), 12'(s0)};
        bus_a.sample_valid = 1'b1;
        tick();
        bus_a.sample_valid = 1'b0;
    endtask

    task automatic scan_a(input string tag);
        int n;
        bus_a.finish = 1'b1;
        tick();
        bus_a.finish = 1'b0;
        n = 0;
        while (!bus_a.label_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus_a.label_valid), 32'd1);
    endtask

    task automatic release_a();
        bus_a.label_ready = 1'b1;
        tick();
        bus_a.label_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_a.sample = '0; bus_a.sample_valid = 1'b0; bus_a.finish = 1'b0; bus_a.label_ready = 1'b0;
        bus_b.sample = '0; bus_b.sample_valid = 1'b0; bus_b.finish = 1'b0; bus_b.label_ready = 1'b0;
        tick();
        tick();
        check("rst_label", 32'(bus_a.label), 32'd0);
        check("rst_score", 32'(bus_a.best_score), 32'd0);
        check("rst_valid", 32'(bus_a.label_valid), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_overrun", 32'(bus_a.overrun), 32'd0);
        reset = 1'b1;
        tick();

        // Test 1: totals {8,12}, latency check edge by edge
        put_a(3, 7);
        put_a(5, 1);
        put_a(0, 4);
        bus_a.finish = 1'b1;
        tick();
        bus_a.finish = 1'b0;
        check("t1_valid_e1", 32'(bus_a.label_valid), 32'd0);
        check("t1_busy", 32'(bus_a.busy), 32'd1);
        tick();
        check("t1_valid_e2", 32'(bus_a.label_valid), 32'd0);
        tick();
        check("t1_valid_e3", 32'(bus_a.label_valid), 32'd1);
        check("t1_label", 32'(bus_a.label), 32'd1);
        check("t1_score", 32'(bus_a.best_score), 32'd12);
        release_a();
        check("t1_valid_drop", 32'(bus_a.label_valid), 32'd0);
        check("t1_busy_drop", 32'(bus_a.busy), 32'd0);

        // Test 2: tie goes to lowest index
        put_a(6, 2);
        put_a(0, 4);
        scan_a("t2");
        check("t2_label", 32'(bus_a.label), 32'd0);
        check("t2_score", 32'(bus_a.best_score), 32'd6);

        // Test 4: outputs stable while ready low, then accumulators cleared
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 32'(bus_a.label_valid), 32'd1);
            check("t4_hold_label", 32'(bus_a.label), 32'd0);
            check("t4_hold_score", 32'(bus_a.best_score), 32'd6);
        end
        release_a();
        check("t4_valid_drop", 32'(bus_a.label_valid), 32'd0);
        scan_a("t4_zero");
        check("t4_zero_label", 32'(bus_a.label), 32'd0);
        check("t4_zero_score", 32'(bus_a.best_score), 32'd0);
        release_a();
        put_a(2, 5);
        scan_a("t4_next");
        check("t4_next_label", 32'(bus_a.label), 32'd1);
        check("t4_next_score", 32'(bus_a.best_score), 32'd5);
        release_a();

        // Test 5: sample and finish on the same edge; overrun in HOLD
        put_a(5, 0);
        bus_a.sample       = {12'd9, 12'd0};
        bus_a.sample_valid = 1'b1;
        bus_a.finish       = 1'b1;
        tick();
        bus_a.sample_valid = 1'b0;
        bus_a.finish       = 1'b0;
        for (int n = 0; n < 8 && !bus_a.label_valid; n++) tick();
        check("t5_valid", 32'(bus_a.label_valid), 32'd1);
        check("t5_label", 32'(bus_a.label), 32'd1);
        check("t5_score", 32'(bus_a.best_score), 32'd9);
        check("t5_overrun_pre", 32'(bus_a.overrun), 32'd0);
        put_a(100, 100);
        check("t5_overrun", 32'(bus_a.overrun), 32'd1);
        check("t5_label_keep", 32'(bus_a.label), 32'd1);
        check("t5_score_keep", 32'(bus_a.best_score), 32'd9);
        release_a();
        check("t5_overrun_sticky", 32'(bus_a.overrun), 32'd1);
        scan_a("t5_zero");
        check("t5_zero_score", 32'(bus_a.best_score), 32'd0);
        release_a();

        // Test 3: saturation on the 12-bit accumulator instance
        for (int i = 0; i < 3; i++) begin
            bus_b.sample       = {12'd1, 12'd4095};
            bus_b.sample_valid = 1'b1;
            tick();
        end
        bus_b.sample_valid = 1'b0;
        bus_b.finish       = 1'b1;
        tick();
        bus_b.finish = 1'b0;
        for (int n = 0; n < 8 && !bus_b.label_valid; n++) tick();
        check("t3_valid", 32'(bus_b.label_valid), 32'd1);
        check("t3_label", 32'(bus_b.label), 32'd0);
        check("t3_score", 32'(bus_b.best_score), 32'd4095);
        bus_b.label_ready = 1'b1;
        tick();
        bus_b.label_ready = 1'b0;
        check("t3_valid_drop", 32'(bus_b.label_valid), 32'd0);

        // Test 6: reset during SCAN aborts at once
        put_a(3, 7);
        scan_a("t6_pre");
        check("t6_pre_score", 32'(bus_a.best_score), 32'd7);
        release_a();
        put_a(3, 3);
        bus_a.finish = 1'b1;
        tick();
        bus_a.finish = 1'b0;
        check("t6_in_scan", 32'(bus_a.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus_a.label_valid), 32'd0);
        check("t6_rst_label", 32'(bus_a.label), 32'd0);
        check("t6_rst_score", 32'(bus_a.best_score), 32'd0);
        check("t6_rst_busy", 32'(bus_a.busy), 32'd0);
        check("t6_rst_overrun", 32'(bus_a.overrun), 32'd0);
        tick();
        check("t6_no_label", 32'(bus_a.label_valid), 32'd0);
        reset = 1'b1;
        tick();
        put_a(1, 2);
        scan_a("t6_post");
        check("t6_post_label", 32'(bus_a.label), 32'd1);
        check("t6_post_score", 32'(bus_a.best_score), 32'd2);
        release_a();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
